// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder.
//   phase_t    : the four Gray phases of the {A,B} pair
//   quad_dir_t : per-cycle decode result {valid, up, illegal}
//   DIR_UP/DIR_DN : encoding of the u_d output
//   quad_dir() : classify a transition between two phases
package quad_pkg;

    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH01 = 2'b01,
        PH11 = 2'b11,
        PH10 = 2'b10
    } phase_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } quad_dir_t;

    // Forward neighbour of {a,b} is {b,~a}; reverse neighbour is {~b,a}.
    function automatic quad_dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        quad_dir_t r;
        logic fwd;
        logic rev;
        fwd       = (cur == {prev[0], ~prev[1]});
        rev       = (cur == {~prev[0], prev[1]});
        r.valid   = fwd | rev;
        r.up      = fwd;
        r.illegal = ((prev ^ cur) == 2'b11);
        return r;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder/counter bundle for quad_decoder.
//   a_in, b_in : encoder phases (asynchronous)
//   en, clr    : count enable, synchronous clear
//   q          : position count (WIDTH bits)
//   u_d, step, err : direction, step pulse, sticky illegal flag
// master drives the encoder/control side; slave is the decoder.
interface quad_decoder_if #(
    parameter int WIDTH = 4
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             u_d;
    logic             step;
    logic             err;

    modport master (
        output a_in, b_in, en, clr,
        input  q, u_d, step, err
    );

    modport slave (
        input  a_in, b_in, en, clr,
        output q, u_d, step, err
    );
endinterface

// File: rtl/quad_decoder_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
//   clk, rst_n : clock and reset (flops reset to 0)
//   d          : asynchronous input
//   q          : synchronised output, STAGES clocks later
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder with wrap-around up/down position counter.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : quad_decoder_if.slave (a_in/b_in/en/clr in; q/u_d/step/err out)
// The FSM holds the last accepted phase; every change of the synchronised
// pair is accepted (illegal jumps resynchronise the FSM but are not counted).
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    quad_decoder_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             a_s;
    logic             b_s;
    logic [1:0]       ab;
    phase_t           state_q;
    phase_t           state_d;
    quad_dir_t        dir;
    logic [WIDTH-1:0] q_r;
    logic             u_d_r;
    logic             step_r;
    logic             err_r;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.a_in),
        .q     (a_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.b_in),
        .q     (b_s)
    );

    assign ab = {a_s, b_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PH00;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir     = quad_dir(state_q, ab);
        if (ab != state_q) begin
            state_d = phase_t'(ab);
        end
    end

    // clr overrides both a coincident count and a coincident illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            u_d_r  <= DIR_UP;
            step_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            step_r <= dir.valid;
            if (dir.valid) begin
                u_d_r <= dir.up ? DIR_UP : DIR_DN;
            end
            if (bus.clr) begin
                q_r   <= '0;
                err_r <= 1'b0;
            end else begin
                if (bus.en && dir.valid) begin
                    q_r <= dir.up ? (q_r + ONE) : (q_r - ONE);
                end
                if (dir.illegal) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.u_d  = u_d_r;
    assign bus.step = step_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;
    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int MOD   = 1 << WIDTH;

    logic clk;
    logic rst_n;

    quad_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int step_cnt;

    // Reference model: phases as positions 0..3 around the Gray circle
    // (00,01,11,10); the modular distance between positions decides the event.
    logic [1:0] tab [4];
    int   m_hist [SYNC];
    int   m_ph;
    int   m_q;
    logic m_ud;
    logic m_step;
    logic m_err;

    initial begin
        tab[0] = 2'b00;
        tab[1] = 2'b01;
        tab[2] = 2'b11;
        tab[3] = 2'b10;
    end

    function automatic int pos_of(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int delta(input int cur, input int prev);
        return (cur - prev + 4) % 4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] <= 0;
            m_ph   <= 0;
            m_q    <= 0;
            m_ud   <= 1'b1;
            m_step <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_hist[0] <= pos_of(bus.a_in, bus.b_in);
            for (int i = 1; i < SYNC; i++) m_hist[i] <= m_hist[i-1];
            m_ph   <= m_hist[SYNC-1];
            m_step <= (delta(m_hist[SYNC-1], m_ph) == 1) || (delta(m_hist[SYNC-1], m_ph) == 3);
            if (delta(m_hist[SYNC-1], m_ph) == 1) m_ud <= 1'b1;
            else if (delta(m_hist[SYNC-1], m_ph) == 3) m_ud <= 1'b0;
            if (bus.clr) begin
                m_q   <= 0;
                m_err <= 1'b0;
            end else begin
                if (bus.en && delta(m_hist[SYNC-1], m_ph) == 1) m_q <= (m_q + 1) % MOD;
                else if (bus.en && delta(m_hist[SYNC-1], m_ph) == 3) m_q <= (m_q + MOD - 1) % MOD;
                if (delta(m_hist[SYNC-1], m_ph) == 2) m_err <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge and compare everything to the model.
    task automatic cyc();
        @(negedge clk);
        check("model_q",    32'(bus.q),    32'(m_q));
        check("model_u_d",  32'(bus.u_d),  32'(m_ud));
        check("model_step", 32'(bus.step), 32'(m_step));
        check("model_err",  32'(bus.err),  32'(m_err));
        if (bus.step === 1'b1) step_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_pos(input int p);
        bus.a_in = tab[p][1];
        bus.b_in = tab[p][0];
    endtask

    task automatic phase_seq4(input int p);
        set_pos(p);
        run(4);
    endtask

    int cur_pos;
    int r;

    initial begin
        tests    = 0;
        fails    = 0;
        step_cnt = 0;
        rst_n    = 1'b0;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        bus.en   = 1'b1;
        bus.clr  = 1'b0;

        // Reset state
        run(3);
        check("rst_q",    32'(bus.q),    32'd0);
        check("rst_u_d",  32'(bus.u_d),  32'd1);
        check("rst_step", 32'(bus.step), 32'd0);
        check("rst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;
        run(2);

        // Forward revolution with latency check
        step_cnt = 0;
        set_pos(1);
        cyc();
        check("lat_e1", 32'(bus.step), 32'd0);
        cyc();
        check("lat_e2", 32'(bus.step), 32'd0);
        cyc();
        check("lat_e3", 32'(bus.step), 32'd1);
        cyc();
        phase_seq4(2);
        phase_seq4(3);
        phase_seq4(0);
        check("fwd_steps", 32'(step_cnt), 32'd4);
        check("fwd_q",     32'(bus.q),    32'd4);
        check("fwd_u_d",   32'(bus.u_d),  32'd1);
        check("fwd_err",   32'(bus.err),  32'd0);

        // Clear, reverse revolution with wrap, then one forward step
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check("clr_q", 32'(bus.q), 32'd0);
        phase_seq4(3);
        phase_seq4(2);
        phase_seq4(1);
        phase_seq4(0);
        check("rev_q",   32'(bus.q),   32'd12);
        check("rev_u_d", 32'(bus.u_d), 32'd0);
        phase_seq4(1);
        check("rev_fwd_q",   32'(bus.q),   32'd13);
        check("rev_fwd_u_d", 32'(bus.u_d), 32'd1);

        // Illegal jump 00 -> 11, then legal 11 -> 10
        phase_seq4(0);
        check("pre_ill_q", 32'(bus.q), 32'd12);
        step_cnt = 0;
        phase_seq4(2);
        check("ill_err",   32'(bus.err),  32'd1);
        check("ill_steps", 32'(step_cnt), 32'd0);
        check("ill_q",     32'(bus.q),    32'd12);
        phase_seq4(3);
        check("post_ill_q", 32'(bus.q), 32'd13);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check("clr2_q",   32'(bus.q),   32'd0);
        check("clr2_err", 32'(bus.err), 32'd0);

        // Count enable low: steps still pulse, q frozen
        bus.en   = 1'b0;
        step_cnt = 0;
        phase_seq4(0);
        phase_seq4(1);
        phase_seq4(2);
        check("en0_steps", 32'(step_cnt), 32'd3);
        check("en0_q",     32'(bus.q),    32'd0);
        bus.en = 1'b1;
        phase_seq4(3);
        check("en1_q", 32'(bus.q), 32'd1);

        // Reach q=7, then clear coincident with the decoded up-step
        phase_seq4(0);
        phase_seq4(1);
        phase_seq4(2);
        phase_seq4(3);
        phase_seq4(0);
        phase_seq4(1);
        check("pre_clr_q", 32'(bus.q), 32'd7);
        set_pos(2);
        cyc();
        cyc();
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check("clrstep_step", 32'(bus.step), 32'd1);
        check("clrstep_q",    32'(bus.q),    32'd0);
        check("clrstep_u_d",  32'(bus.u_d),  32'd1);
        run(2);

        // Asynchronous reset mid-sequence after moving q and u_d away from reset values
        phase_seq4(3);
        phase_seq4(2);
        phase_seq4(1);
        check("pre_rst_q",   32'(bus.q),   32'd15);
        check("pre_rst_u_d", 32'(bus.u_d), 32'd0);
        set_pos(0);
        cyc();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q",    32'(bus.q),    32'd0);
        check("arst_u_d",  32'(bus.u_d),  32'd1);
        check("arst_step", 32'(bus.step), 32'd0);
        check("arst_err",  32'(bus.err),  32'd0);

        // Encoder resting at 01 during reset counts one step on release
        set_pos(1);
        cyc();
        rst_n    = 1'b1;
        step_cnt = 0;
        run(4);
        check("rel01_steps", 32'(step_cnt), 32'd1);
        check("rel01_q",     32'(bus.q),    32'd1);

        // Randomised walk checked cycle by cycle against the model
        cur_pos = 1;
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       cur_pos = (cur_pos + 1) % 4;
            else if (r < 8)  cur_pos = (cur_pos + 3) % 4;
            else if (r == 8) cur_pos = (cur_pos + 2) % 4;
            set_pos(cur_pos);
            bus.en  = ($urandom_range(0, 4) != 0);
            bus.clr = ($urandom_range(0, 19) == 0);
            cyc();
            bus.clr = 1'b0;
            run(int'($urandom_range(0, 3)));
        end
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder with up/down position counter; the input-side counterpart of the team's up/down counter. It accepts two phase-shifted square waves (A, B) from an incremental encoder and synchronises them into the `clk` domain. It tracks the 2-bit Gray phase with a 4-state FSM and derives direction (`u_d`) and per-step pulses that drive a wrap-around position counter. Illegal double-bit phase jumps are flagged, not counted.

## Interface
- `WIDTH`, 4: position counter width (≥2).
- `SYNC_STAGES`, 2: synchroniser depth on `a_in` / `b_in` (≥2).

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_in`  in  1  encoder phase A; asynchronous to `clk`.
- `b_in`  in  1  encoder phase B; asynchronous to `clk`.
- `en`  in  1  count enable; phase tracking continues when low.
- `clr`  in  1  synchronous clear of `q` and `err`.
- `q`  out  WIDTH  position count.
- `u_d`  out  1  direction of last valid step: 1 = up, 0 = down.
- `step`  out  1  one-cycle pulse per valid phase step (independent of `en`).
- `err`  out  1  sticky illegal-transition flag.

## Operation
- Synchroniser: `a_in` and `b_in` each pass through `SYNC_STAGES` flops, reset to 0. The synchronised pair is `ab = {a_s, b_s}`.
- FSM holds the last accepted phase. States are `PH00`, `PH01`, `PH11`, `PH10`; reset state is `PH00`.
- Each cycle, compare `ab` with the state:
  - Equal: no event.
  - Forward neighbour (00→01→11→10→00): step up. State ← `ab`, `step`=1, `u_d`←1, and `q`←`q`+1 if `en`.
  - Reverse neighbour (00→10→11→01→00): step down. State ← `ab`, `step`=1, `u_d`←0, and `q`←`q`−1 if `en`.
  - Both bits differ: illegal. State ← `ab` (resynchronise), `err`←1, `step`=0, `q` and `u_d` unchanged.
- Arithmetic is modulo 2^WIDTH:
  - Up from all-ones wraps to 0.
  - Down from 0 wraps to all-ones.
  - No saturation, no carry output.
- `en`=0:
  - FSM, `step`, `u_d` and `err` still update.
  - Only `q` is frozen.
  - Re-enabling produces no spurious count.
- `clr`=1:
  - `q`←0 and `err`←0 at the next edge.
  - FSM and `u_d` continue normally.
  - `clr` beats a simultaneous step (that step is lost from `q`) and beats a simultaneous illegal transition (`err` ends 0).
- Reset values: `q`=0, `u_d`=1, `step`=0, `err`=0, FSM=`PH00`, synchroniser flops=0.
- Reset asserted mid-operation clears everything immediately (asynchronous).
- After reset release, if the encoder rests at a phase other than 00, the first decode is against `PH00`:
  - 01 or 10 counts one step.
  - 11 flags `err`.
  - This behaviour is accepted; software issues `clr` after reset.

## Timing
- Latency from an input edge to its `step` / `q` / `u_d` update: `SYNC_STAGES`+1 clock edges (3 with defaults).
- `step` is high for exactly one cycle per accepted transition.
- Maximum trackable rate is one phase change per clock. The input edge spacing must be ≥2 clocks for guaranteed legal decode; closer spacing may appear as an illegal transition.
- `err` stays set until `clr` or reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `quad_pkg`:
  - Phase state enum (`PH00`, `PH01`, `PH11`, `PH10`).
  - Constants `DIR_UP`=1 and `DIR_DN`=0.
  - A function `quad_dir(prev, cur)` returning {valid, up, illegal}.
- Sub-module `sync_ff`: parameterised `SYNC_STAGES` single-bit synchroniser with async active-low reset; instantiated twice.
- Top level: FSM, decode, counter, and flag registers.

## Test plan
- Reset, then drive ab sequence 01, 11, 10, 00 with each phase held 4 clocks → 4 `step` pulses, `u_d`=1, `q`=4, `err`=0; first `step` appears 3 clocks after the first `a_in`/`b_in` change.
- From `q`=0 drive reverse 10, 11, 01, 00 → `q`=12 (0xC, wrapped), `u_d`=0; then one forward step → `q`=13, `u_d`=1.
- From `PH00` jump directly to ab=11 → `err`=1, no `step`, `q` unchanged. The following legal step 11→10 counts up. Assert `clr` → `q`=0, `err`=0.
- Hold `en`=0 over 3 forward steps → 3 `step` pulses, `q` unchanged. Raise `en` and take 1 step → `q` increments by exactly 1.
- Assert `clr` in the same cycle as a decoded up-step from `q`=7 → `q`=0 and `u_d`=1. Assert `rst_n`=0 mid-sequence → all outputs at reset values before the next clock edge.
